cmd_serial_to_parallel: RTL and testbench

- CMD-line receive wrapper (S-P) between the CMD pad and the CMD physical-layer controller.
- When the controller enables it, the block hunts for a response start bit on the serial CMD input and shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) frame, MSB first.
- It checks the CRC7, the transmission bit and the end bit, then presents the frame as pad_response with reception_complete held high until released.

---
 rtl/cmd_serial_to_parallel.sv | 138 +++++++++++++
 tb/tb_cmd_serial_to_parallel.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cmd_serial_to_parallel.sv
// rtl/cmd_serial_to_parallel.sv - CMD-line response receiver: start-bit hunt, shift-in, CRC7 and framing check
module cmd_serial_to_parallel #(
  parameter int LONG_LEN  = 136,
  parameter int SHORT_LEN = 48,
  parameter int CNT_W     = 8
) (
  input  logic                sd_clock,
  input  logic                reset,
  input  logic                reset_wrapper,
  input  logic                enable_stp_wrapper,
  input  logic                long_response,
  input  logic                cmd_in,
  output logic [LONG_LEN-1:0] pad_response,
  output logic                reception_complete,
  output logic                crc_error,
  output logic                frame_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HUNT = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0] SHORT_LAST    = CNT_W'(SHORT_LEN - 1);
  localparam logic [CNT_W-1:0] LONG_LAST     = CNT_W'(LONG_LEN - 1);
  localparam logic [CNT_W-1:0] SHORT_CRC_END = CNT_W'(SHORT_LEN - 9);
  localparam logic [CNT_W-1:0] LONG_CRC_BEG  = CNT_W'(LONG_LEN - 128);
  localparam logic [CNT_W-1:0] LONG_CRC_END  = CNT_W'(LONG_LEN - 9);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [6:0]          crc_q, crc_d;
  logic [LONG_LEN-2:0] shift_q, shift_d;
  logic                len_sel_q, len_sel_d;
  logic [LONG_LEN-1:0] pad_q, pad_d;
  logic                done_q, done_d;
  logic                crc_err_q, crc_err_d;
  logic                frm_err_q, frm_err_d;

  logic [LONG_LEN-1:0] frame_nxt;
  logic [6:0]          crc_upd;
  logic                fb;
  logic                last_bit;
  logic                crc_en;

  always_comb begin
    frame_nxt = {shift_q, cmd_in};
    fb        = cmd_in ^ crc_q[6];
    crc_upd   = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
    last_bit  = len_sel_q ? (cnt_q == LONG_LAST) : (cnt_q == SHORT_LAST);
    // Long frames skip start, transmission and reserved bits; both skip CRC and end bits.
    crc_en    = len_sel_q ? ((cnt_q >= LONG_CRC_BEG) && (cnt_q <= LONG_CRC_END))
                          : (cnt_q <= SHORT_CRC_END);

    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    shift_d   = shift_q;
    len_sel_d = len_sel_q;
    pad_d     = pad_q;
    done_d    = done_q;
    crc_err_d = crc_err_q;
    frm_err_d = frm_err_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_stp_wrapper) state_d = ST_HUNT;
      end
      ST_HUNT: begin
        if (!enable_stp_wrapper) begin
          state_d = ST_IDLE;
        end else if (!cmd_in) begin
          len_sel_d = long_response;
          shift_d   = '0;
          cnt_d     = CNT_W'(1);
          crc_d     = '0;
          pad_d     = '0;
          state_d   = ST_RECV;
        end
      end
      ST_RECV: begin
        if (!enable_stp_wrapper) begin
          state_d = ST_IDLE;
        end else begin
          shift_d = frame_nxt[LONG_LEN-2:0];
          cnt_d   = cnt_q + CNT_W'(1);
          if (crc_en) crc_d = crc_upd;
          if (last_bit) begin
            state_d   = ST_DONE;
            pad_d     = frame_nxt;
            done_d    = 1'b1;
            crc_err_d = (frame_nxt[7:1] != crc_q);
            frm_err_d = (len_sel_q ? frame_nxt[LONG_LEN-2] : frame_nxt[SHORT_LEN-2])
                        | ~frame_nxt[0];
          end
        end
      end
      default: begin
        if (!enable_stp_wrapper) begin
          state_d   = ST_IDLE;
          done_d    = 1'b0;
          crc_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge sd_clock) begin
    if (reset || !reset_wrapper) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      crc_q     <= '0;
      shift_q   <= '0;
      len_sel_q <= 1'b0;
      pad_q     <= '0;
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      shift_q   <= shift_d;
      len_sel_q <= len_sel_d;
      pad_q     <= pad_d;
      done_q    <= done_d;
      crc_err_q <= crc_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign pad_response       = pad_q;
  assign reception_complete = done_q;
  assign crc_error          = crc_err_q;
  assign frame_error        = frm_err_q;

endmodule

// File: tb/tb_cmd_serial_to_parallel.sv
// tb/tb_cmd_serial_to_parallel.sv - self-checking bench for cmd_serial_to_parallel
module tb_cmd_serial_to_parallel;

  logic         sd_clock = 1'b0;
  logic         reset = 1'b1;
  logic         reset_wrapper = 1'b1;
  logic         enable_stp_wrapper = 1'b0;
  logic         long_response = 1'b0;
  logic         cmd_in = 1'b1;
  logic [135:0] pad_response;
  logic         reception_complete;
  logic         crc_error;
  logic         frame_error;

  int checks = 0;
  int errors = 0;

  cmd_serial_to_parallel dut (
    .sd_clock           (sd_clock),
    .reset              (reset),
    .reset_wrapper      (reset_wrapper),
    .enable_stp_wrapper (enable_stp_wrapper),
    .long_response      (long_response),
    .cmd_in             (cmd_in),
    .pad_response       (pad_response),
    .reception_complete (reception_complete),
    .crc_error          (crc_error),
    .frame_error        (frame_error)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference CRC7 by polynomial long division over frame bits hi..lo.
  function automatic logic [6:0] crc7_ref(input logic [135:0] f, input int hi, input int lo);
    logic [6:0] c = '0;
    logic       m;
    for (int i = hi; i >= lo; i--) begin
      m = c[6] ^ f[i];
      c = {c[5:0], 1'b0};
      if (m) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [135:0] make_short(input logic [37:0] body);
    logic [135:0] f = '0;
    f[47:0] = {2'b00, body, 7'b0, 1'b1};
    f[7:1]  = crc7_ref(f, 47, 8);
    return f;
  endfunction

  function automatic logic [135:0] make_long(input logic [119:0] cid);
    logic [135:0] f = {8'h3F, cid, 7'b0, 1'b1};
    f[7:1] = crc7_ref(f, 127, 8);
    return f;
  endfunction

  function automatic logic model_crc_err(input logic [135:0] f, input int len);
    return f[7:1] != crc7_ref(f, (len == 136) ? 127 : 47, 8);
  endfunction

  function automatic logic model_frm_err(input logic [135:0] f, input int len);
    return f[len-2] | ~f[0];
  endfunction

  task automatic run_frame(input logic [135:0] f, input int len, input bit lng, input int idle,
                           input logic exp_crc, input logic exp_frm, input bit release_en,
                           input string tag);
    @(negedge sd_clock);
    long_response      = lng;
    enable_stp_wrapper = 1'b1;
    cmd_in             = 1'b1;
    repeat (idle - 1) @(negedge sd_clock);
    for (int i = len - 1; i >= 0; i--) begin
      @(negedge sd_clock);
      if (i == 0) check({tag, "_early"}, 136'(reception_complete), 136'(0));
      cmd_in = f[i];
    end
    @(posedge sd_clock); #1;
    check({tag, "_done"}, 136'(reception_complete), 136'(1));
    check({tag, "_pad"}, pad_response, f);
    check({tag, "_crc"}, 136'(crc_error), 136'(exp_crc));
    check({tag, "_frm"}, 136'(frame_error), 136'(exp_frm));
    repeat (3) begin
      @(negedge sd_clock);
      cmd_in = 1'($urandom);
    end
    @(posedge sd_clock); #1;
    check({tag, "_hold_pad"}, pad_response, f);
    check({tag, "_hold_done"}, 136'(reception_complete), 136'(1));
    if (release_en) begin
      @(negedge sd_clock);
      enable_stp_wrapper = 1'b0;
      cmd_in             = 1'b1;
      @(posedge sd_clock); #1;
      check({tag, "_rel_done"}, 136'(reception_complete), 136'(0));
      check({tag, "_rel_flags"}, 136'({crc_error, frame_error}), 136'(0));
      check({tag, "_rel_pad"}, pad_response, f);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pad"}, pad_response, 136'(0));
    check({tag, "_done"}, 136'(reception_complete), 136'(0));
    check({tag, "_crc"}, 136'(crc_error), 136'(0));
    check({tag, "_frm"}, 136'(frame_error), 136'(0));
  endtask

  initial begin
    logic [135:0] f;
    logic [135:0] r1;
    bit           lng;
    int           len;

    repeat (3) @(posedge sd_clock);
    #1;
    check_cleared("reset");
    @(negedge sd_clock);
    reset = 1'b0;

    r1 = 136'h11_0000_0900_67;
    run_frame(r1, 48, 1'b0, 4, 1'b0, 1'b0, 1'b1, "r1");
    f = 136'h40_0000_0000_95;
    run_frame(f, 48, 1'b0, 2, 1'b0, 1'b1, 1'b1, "tbit");
    f = 136'h11_0000_0900_6F;
    run_frame(f, 48, 1'b0, 1, 1'b1, 1'b0, 1'b1, "crcbad");
    f = 136'h11_0000_0900_66;
    run_frame(f, 48, 1'b0, 3, 1'b0, 1'b1, 1'b1, "endbad");

    f = make_long({$urandom, $urandom, $urandom, 24'($urandom)});
    run_frame(f, 136, 1'b1, 2, 1'b0, 1'b0, 1'b1, "r2");
    f[130] = ~f[130];
    run_frame(f, 136, 1'b1, 1, 1'b0, 1'b0, 1'b1, "r2rsv");

    // Abort after 20 bits, then a clean frame.
    @(negedge sd_clock);
    long_response      = 1'b0;
    enable_stp_wrapper = 1'b1;
    cmd_in             = 1'b1;
    for (int i = 47; i > 27; i--) begin
      @(negedge sd_clock);
      cmd_in = r1[i];
    end
    @(negedge sd_clock);
    enable_stp_wrapper = 1'b0;
    cmd_in             = 1'b1;
    repeat (2) @(posedge sd_clock);
    #1;
    check_cleared("abort");
    run_frame(r1, 48, 1'b0, 2, 1'b0, 1'b0, 1'b1, "after_abort");

    // Random frames, some with a corrupted bit.
    for (int n = 0; n < 10; n++) begin
      lng = 1'($urandom);
      len = lng ? 136 : 48;
      f = lng ? make_long({$urandom, $urandom, $urandom, 24'($urandom)})
              : make_short({6'($urandom), $urandom});
      if ($urandom_range(0, 2) == 0) f[$urandom_range(0, len - 2)] ^= 1'b1;
      run_frame(f, len, lng, $urandom_range(1, 5), model_crc_err(f, len),
                model_frm_err(f, len), 1'b1, $sformatf("rnd%0d", n));
    end

    // reset_wrapper in DONE, then reset mid-receive.
    run_frame(r1, 48, 1'b0, 2, 1'b0, 1'b0, 1'b0, "pre_rw");
    @(negedge sd_clock);
    reset_wrapper = 1'b0;
    cmd_in        = 1'b1;
    @(posedge sd_clock); #1;
    check_cleared("rst_wrap");
    @(negedge sd_clock);
    reset_wrapper = 1'b1;
    for (int i = 47; i > 37; i--) begin
      @(negedge sd_clock);
      cmd_in = r1[i];
    end
    @(negedge sd_clock);
    reset  = 1'b1;
    cmd_in = 1'b1;
    @(posedge sd_clock); #1;
    check_cleared("rst_mid");
    @(negedge sd_clock);
    reset = 1'b0;
    repeat (60) @(posedge sd_clock);
    #1;
    check_cleared("rst_hunt");
    run_frame(r1, 48, 1'b0, 1, 1'b0, 1'b0, 1'b1, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
